// File: rtl/datapath.sv
// Execution stage behind the instruction controller: ADD/SUB in one step,
// shift-add MUL and restoring DIV over eight iterations, with a done pulse.
module datapath #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [3:0]       opcode,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;

   state_t      state_r, state_nxt_s;
   logic        enable_q_r;
   logic [7:0]  a_r, b_r;
   logic [1:0]  op_r;
   logic [2:0]  cnt_r, cnt_nxt_s;
   logic [15:0] acc_r, acc_nxt_s;
   logic [15:0] result_r, result_nxt_s;
   logic        dbz_r, dbz_nxt_s;
   logic        start_s, single_s;
   logic [15:0] step_s;
   logic [8:0]  trial_s;
   logic [7:0]  rem_sub_s;

   assign start_s  = (state_r == ST_IDLE) && enable && !enable_q_r && (opcode <= 4'd3);
   assign single_s = (op_r == OP_ADD) || (op_r == OP_SUB) || ((op_r == OP_DIV) && (b_r == 8'd0));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) state_nxt_s = ST_RUN;
            else         state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (single_s || (cnt_r == 3'd7)) state_nxt_s = ST_DONE;
            else                             state_nxt_s = ST_RUN;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // One multi-cycle iteration; DIV keeps {remainder, quotient} in the accumulator
   always_comb begin
      step_s    = acc_r;
      trial_s   = {acc_r[15:8], a_r[3'd7 - cnt_r]};
      rem_sub_s = trial_s[7:0] - b_r;
      case (op_r)
         OP_MUL: begin
            if (b_r[cnt_r]) step_s = acc_r + ({8'd0, a_r} << cnt_r);
            else            step_s = acc_r;
         end
         OP_DIV: begin
            if (trial_s >= {1'b0, b_r}) step_s = {rem_sub_s, acc_r[6:0], 1'b1};
            else                        step_s = {trial_s[7:0], acc_r[6:0], 1'b0};
         end
         default: step_s = acc_r;
      endcase
   end

   // Datapath next values
   always_comb begin
      cnt_nxt_s    = cnt_r;
      acc_nxt_s    = acc_r;
      result_nxt_s = result_r;
      dbz_nxt_s    = dbz_r;
      if (start_s) begin
         cnt_nxt_s = 3'd0;
         acc_nxt_s = 16'd0;
         dbz_nxt_s = 1'b0;
      end else if (state_r == ST_RUN) begin
         if (single_s) begin
            case (op_r)
               OP_ADD:  result_nxt_s = {8'd0, a_r} + {8'd0, b_r};
               OP_SUB:  result_nxt_s = {8'd0, a_r} - {8'd0, b_r};
               OP_DIV: begin
                  result_nxt_s = {a_r, 8'hFF};
                  dbz_nxt_s    = 1'b1;
               end
               default: result_nxt_s = result_r;
            endcase
         end else begin
            acc_nxt_s = step_s;
            if (cnt_r == 3'd7) begin
               // final iteration commits on the same edge as the move to DONE
               result_nxt_s = step_s;
               cnt_nxt_s    = 3'd0;
            end else begin
               cnt_nxt_s = cnt_r + 3'd1;
            end
         end
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Datapath registers and operand capture
   always_ff @(posedge clk) begin
      if (reset) begin
         enable_q_r <= 1'b0;
         a_r        <= 8'd0;
         b_r        <= 8'd0;
         op_r       <= 2'd0;
         cnt_r      <= 3'd0;
         acc_r      <= 16'd0;
         result_r   <= 16'd0;
         dbz_r      <= 1'b0;
      end else begin
         enable_q_r <= enable;
         if (start_s) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= opcode[1:0];
         end
         cnt_r    <= cnt_nxt_s;
         acc_r    <= acc_nxt_s;
         result_r <= result_nxt_s;
         dbz_r    <= dbz_nxt_s;
      end
   end

   assign result      = WIDTH'(result_r);
   assign div_by_zero = dbz_r;
   assign done        = (state_r == ST_DONE);
   assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: expected results are queued at the start edge
// and compared when done pulses; handshake and reset-abort cases included.
module tb_datapath;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [3:0]  opcode;
   logic [7:0]  a, b;
   logic [15:0] result;
   logic        done, busy, div_by_zero;

   typedef struct {
      logic [15:0] res;
      logic        dbz;
      int          lat;
      int          start;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] last_res = 16'd0;

   datapath #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .a(a), .b(b),
      .result(result), .done(done), .busy(busy), .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: pop and compare on every done pulse
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("result", {16'd0, result}, {16'd0, e.res});
            check_eq("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            check_eq("latency", cyc - e.start, e.lat);
         end
      end
   end

   task automatic run_op(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] er, input logic ed, input int lat, input int hold);
      int busy_cnt;
      int hi_cnt;
      exp_t e;
      @(negedge clk);
      enable = 1'b1; opcode = op; a = aa; b = bb;
      @(posedge clk); #1;
      e.res = er; e.dbz = ed; e.lat = lat; e.start = cyc;
      exp_q.push_back(e);
      last_res = er;
      busy_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         else break;
      end
      check_eq("busy_cycles", busy_cnt, lat + 1);
      if (hold > 0) begin
         hi_cnt = 0;
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (busy) hi_cnt++;
         end
         check_eq("no_relaunch", hi_cnt, 0);
      end
      enable = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int hi_cnt;
      logic [7:0] ra, rb;
      reset = 1'b1; enable = 1'b0; opcode = 4'd0; a = 8'd0; b = 8'd0;
      repeat (3) @(negedge clk);
      check_eq("rst_result", {16'd0, result}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(4'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1, 0);
      run_op(4'd1, 8'd3,   8'd5,   16'hFFFE, 1'b0, 1, 0);
      run_op(4'd1, 8'd5,   8'd3,   16'h0002, 1'b0, 1, 0);
      run_op(4'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 8, 0);
      run_op(4'd2, 8'd0,   8'd77,  16'h0000, 1'b0, 8, 0);
      run_op(4'd3, 8'd200, 8'd7,   16'h041C, 1'b0, 8, 0);
      run_op(4'd3, 8'd9,   8'd0,   16'h09FF, 1'b1, 1, 0);

      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         run_op(4'd2, ra, rb, 16'(ra) * 16'(rb), 1'b0, 8, 0);
         run_op(4'd3, ra, rb, {8'(ra % rb), 8'(ra / rb)}, 1'b0, 8, 0);
      end

      // Unexecuted opcode: nothing starts, result holds
      @(negedge clk);
      enable = 1'b1; opcode = 4'd4; a = 8'd1; b = 8'd1;
      hi_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy) hi_cnt++;
      end
      check_eq("invalid_op_busy", hi_cnt, 0);
      check_eq("invalid_op_result", {16'd0, result}, {16'd0, last_res});
      enable = 1'b0;
      @(negedge clk);

      // enable held high after done: exactly one done, then relaunch only after a low cycle
      run_op(4'd0, 8'd10, 8'd20, 16'h001E, 1'b0, 1, 10);
      run_op(4'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1, 0);

      // Reset sampled at E4 of a MUL aborts it
      @(negedge clk);
      enable = 1'b1; opcode = 4'd2; a = 8'd255; b = 8'd255;
      @(posedge clk); #1;
      repeat (4) @(negedge clk);
      reset = 1'b1; enable = 1'b0;
      @(negedge clk);
      check_eq("abort_result", {16'd0, result}, 32'd0);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      hi_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (busy) hi_cnt++;
      end
      check_eq("abort_no_resume", hi_cnt, 0);
      run_op(4'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1, 0);

      repeat (3) @(negedge clk);
      check_eq("pending_results", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
